// File: rtl/cap_rf_pkg.sv
// ============================================================================
// Module   : cap_rf_pkg
// Purpose  : Shared widths, null capability and sweep FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cap_rf_pkg;

    localparam int CAP_W_DEF  = 128;
    localparam int CAP_EW_DEF = CAP_W_DEF + 1;

    localparam logic [CAP_EW_DEF-1:0] NULL_CAP = '0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

endpackage : cap_rf_pkg

`default_nettype wire

// File: rtl/cap_rf_sweeper.sv
// ============================================================================
// Module   : cap_rf_sweeper
// Purpose  : Pending-clear mask plus the one-entry-per-cycle sweep engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cap_rf_sweeper
    import cap_rf_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_valid_i,
    input  logic [NREGS-1:0] clr_mask_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    output logic             clr_ready_o,
    output logic             busy_o,
    output logic             clr_stb_o,
    output logic [AW-1:0]    clr_idx_o,
    output logic [NREGS-1:0] pend_o
);

    localparam logic [NREGS-1:0] c_pend_rst = {{(NREGS-1){1'b1}}, 1'b0};
    localparam logic [AW-1:0]    c_last_idx = AW'(NREGS - 1);
    localparam logic [AW-1:0]    c_first_idx = AW'(1);

    sweep_state_e     state_q, state_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic             w_clr_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            cur_q   <= c_first_idx;
            pend_q  <= c_pend_rst;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        w_clr_stb = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_valid_i) begin
                    pend_d    = clr_mask_i;
                    pend_d[0] = 1'b0;
                    cur_d     = c_first_idx;
                    state_d   = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                // A concurrent write to the swept index owns that entry.
                if (pend_q[cur_q] && !(wr_en_i && (wr_addr_i == cur_q))) begin
                    w_clr_stb      = 1'b1;
                    pend_d[cur_q]  = 1'b0;
                end
                cur_d = cur_q + AW'(1);
                if (cur_q == c_last_idx) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SWEEP;
        endcase
        // Applied last so a write supersedes any mask loaded this cycle.
        if (wr_en_i) begin
            pend_d[wr_addr_i] = 1'b0;
        end
    end

    assign clr_ready_o = (state_q == ST_IDLE) && !rst;
    assign busy_o      = (state_q == ST_SWEEP) || rst;
    assign clr_stb_o   = w_clr_stb;
    assign clr_idx_o   = cur_q;
    assign pend_o      = pend_q;

endmodule : cap_rf_sweeper

`default_nettype wire

// File: rtl/cap_regfile_sweep.sv
// ============================================================================
// Module   : cap_regfile_sweep
// Purpose  : Capability register file with atomic masked bulk clear and
//            post-reset sweep. Optional macro CAP_REGFILE_BYPASS_EN enables
//            write-through forwarding on the read ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cap_regfile_sweep
    import cap_rf_pkg::*;
#(
    parameter int CAP_W = CAP_W_DEF,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD*AW-1:0]        ra,
    output logic [NRD*(CAP_W+1)-1:0] rd,
    input  logic                     we,
    input  logic [AW-1:0]            wa,
    input  logic [CAP_W:0]           wd,
    input  logic                     clr_valid,
    input  logic [NREGS-1:0]         clr_mask,
    output logic                     clr_ready,
    output logic                     busy
);

    localparam int                c_cap_ew  = CAP_W + 1;
    localparam logic [c_cap_ew-1:0] c_null  = c_cap_ew'(NULL_CAP);
    localparam logic [AW:0]       c_nregs_x = (AW+1)'(NREGS);

    logic [c_cap_ew-1:0] regs_q [NREGS];
    logic                w_wr_en;
    logic                w_clr_stb;
    logic [AW-1:0]       w_clr_idx;
    logic [NREGS-1:0]    w_pend;

    assign w_wr_en = we && (wa != '0) && ({1'b0, wa} < c_nregs_x) && !rst;

    cap_rf_sweeper #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sweeper (
        .clk         (clk),
        .rst         (rst),
        .clr_valid_i (clr_valid),
        .clr_mask_i  (clr_mask),
        .wr_en_i     (w_wr_en),
        .wr_addr_i   (wa),
        .clr_ready_o (clr_ready),
        .busy_o      (busy),
        .clr_stb_o   (w_clr_stb),
        .clr_idx_o   (w_clr_idx),
        .pend_o      (w_pend)
    );

    always_ff @(posedge clk) begin
        regs_q[0] <= c_null;
        for (int i = 1; i < NREGS; i++) begin
            if (w_wr_en && (wa == AW'(i))) begin
                regs_q[i] <= wd;
            end else if (w_clr_stb && (w_clr_idx == AW'(i))) begin
                regs_q[i] <= c_null;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]       w_addr;
        logic                w_valid;
        logic [c_cap_ew-1:0] w_data;

        assign w_addr  = ra[k*AW +: AW];
        // Pending entries read as null so a clear looks atomic.
        assign w_valid = !rst && (w_addr != '0) && ({1'b0, w_addr} < c_nregs_x)
                         && !w_pend[w_addr];

        always_comb begin
            w_data = w_valid ? regs_q[w_addr] : c_null;
`ifdef CAP_REGFILE_BYPASS_EN
            if (we && !rst && (wa != '0) && (wa == w_addr)) begin
                w_data = wd;
            end
`endif
        end

        assign rd[k*c_cap_ew +: c_cap_ew] = w_data;
    end

endmodule : cap_regfile_sweep

`default_nettype wire

// File: tb/tb_cap_regfile_sweep.sv
// ============================================================================
// Module   : tb_cap_regfile_sweep
// Purpose  : Directed self-checking bench for cap_regfile_sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cap_regfile_sweep;

    localparam int CAP_W = 128;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int EW    = CAP_W + 1;

    localparam logic [EW-1:0] c_dead = {1'b1, 128'hDEAD};
    localparam logic [EW-1:0] c_v11  = EW'(129'h11);
    localparam logic [EW-1:0] c_v22  = EW'(129'h22);
    localparam logic [EW-1:0] c_v33  = EW'(129'h33);
    localparam logic [EW-1:0] c_v44  = EW'(129'h44);
    localparam logic [EW-1:0] c_v55  = EW'(129'h55);
    localparam logic [EW-1:0] c_v66  = EW'(129'h66);
    localparam logic [EW-1:0] c_v70  = EW'(129'h70);
    localparam logic [EW-1:0] c_v86  = EW'(129'h86);
    localparam logic [EW-1:0] c_v88  = EW'(129'h88);
    localparam logic [EW-1:0] c_v99  = EW'(129'h99);

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*EW-1:0]    rd;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [EW-1:0]        wd;
    logic                 clr_valid;
    logic [NREGS-1:0]     clr_mask;
    logic                 clr_ready;
    logic                 busy;

    logic [EW-1:0]        w_rd0;
    logic [EW-1:0]        w_rd1;
    int                   n_tests = 0;
    int                   n_fail  = 0;
    int                   n_cyc;

    assign w_rd0 = rd[EW-1:0];
    assign w_rd1 = rd[2*EW-1:EW];

    cap_regfile_sweep #(
        .CAP_W (CAP_W),
        .NREGS (NREGS),
        .AW    (AW),
        .NRD   (NRD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ra        (ra),
        .rd        (rd),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .clr_valid (clr_valid),
        .clr_mask  (clr_mask),
        .clr_ready (clr_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
        #1;
    endtask

    task automatic wr(input int a, input logic [EW-1:0] d);
        we = 1'b1;
        wa = AW'(a);
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        clr_valid = 1'b0;
        clr_mask  = '0;
        ra        = '0;

        // Reset and post-reset sweep
        rd_at(5, 0);
        check("rst_busy", EW'(busy), EW'(1));
        check("rst_ready", EW'(clr_ready), EW'(0));
        check("rst_rd_r5", w_rd0, '0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rd_r5", w_rd0, '0);
        count_busy(n_cyc);
        check("rst_sweep_len", EW'(n_cyc), EW'(31));
        check("rst_idle_ready", EW'(clr_ready), EW'(1));

        // Basic write/read and r0 hardwiring
        we = 1'b1; wa = AW'(3); wd = c_dead;
        rd_at(3, 0);
`ifdef CAP_REGFILE_BYPASS_EN
        check("wr_same_cycle_r3", w_rd0, c_dead);
`else
        check("wr_same_cycle_r3", w_rd0, '0);
`endif
        tick();
        we = 1'b0;
        #1;
        check("rd_r3", w_rd0, c_dead);
        check("rd_r0", w_rd1, '0);
        wr(0, '1);
        rd_at(0, 3);
        check("r0_after_write", w_rd0, '0);
        check("r3_port1", w_rd1, c_dead);

        // Masked clear atomicity
        wr(1, c_v11); wr(2, c_v22); wr(3, c_v33); wr(4, c_v44);
        clr_valid = 1'b1; clr_mask = 32'h0000_000A;
        tick();
        clr_valid = 1'b0;
        rd_at(1, 3);
        check("mclr_r1", w_rd0, '0);
        check("mclr_r3", w_rd1, '0);
        rd_at(2, 4);
        check("mclr_r2", w_rd0, c_v22);
        check("mclr_r4", w_rd1, c_v44);
        count_busy(n_cyc);
        check("mclr_len", EW'(n_cyc), EW'(31));
        rd_at(2, 1);
        check("mclr_end_r2", w_rd0, c_v22);
        check("mclr_end_r1", w_rd1, '0);

        // Full clear with writes during the sweep
        clr_valid = 1'b1; clr_mask = '1;
        tick();
        clr_valid = 1'b0;
        tick();
        we = 1'b1; wa = AW'(20); wd = c_v55;
        tick();
        we = 1'b0;
        rd_at(20, 2);
        check("sweep_wr_r20", w_rd0, c_v55);
        check("sweep_r2", w_rd1, '0);
        tick();
        tick();
        we = 1'b1; wa = AW'(5); wd = c_v66;
        tick();
        we = 1'b0;
        rd_at(5, 4);
        check("sweep_collide_r5", w_rd0, c_v66);
        check("sweep_r4", w_rd1, '0);
        count_busy(n_cyc);
        check("full_clr_rest_len", EW'(n_cyc), EW'(26));
        rd_at(20, 5);
        check("end_r20", w_rd0, c_v55);
        check("end_r5", w_rd1, c_v66);
        rd_at(2, 31);
        check("end_r2", w_rd0, '0);
        check("end_r31", w_rd1, '0);

        // Busy rejection and reset mid-sweep
        wr(6, c_v86); wr(8, c_v88);
        clr_valid = 1'b1; clr_mask = 32'h0000_0040;
        tick();
        clr_mask = 32'h0000_0100;
        #1;
        n_cyc = 0;
        while (!clr_ready && n_cyc < 200) begin
            n_cyc++;
            tick();
        end
        check("hold_wait_len", EW'(n_cyc), EW'(31));
        rd_at(8, 6);
        check("held_r8", w_rd0, c_v88);
        check("cleared_r6", w_rd1, '0);
        tick();
        clr_valid = 1'b0;
        rd_at(8, 0);
        check("accepted_r8", w_rd0, '0);
        check("accepted_busy", EW'(busy), EW'(1));
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        count_busy(n_cyc);
        check("rst_mid_len", EW'(n_cyc), EW'(31));
        check("rst_mid_ready", EW'(clr_ready), EW'(1));

        // Same-cycle read of a written address
        wr(7, c_v70);
        we = 1'b1; wa = AW'(7); wd = c_v99;
        rd_at(7, 7);
`ifdef CAP_REGFILE_BYPASS_EN
        check("byp_same_r7", w_rd0, c_v99);
`else
        check("byp_same_r7", w_rd0, c_v70);
`endif
        tick();
        we = 1'b0;
        #1;
        check("byp_next_r7_p0", w_rd0, c_v99);
        check("byp_next_r7_p1", w_rd1, c_v99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cap_regfile_sweep

`default_nettype wire
